// File: rtl/rggen_register_access_arbiter_pkg.sv
// Shared types for the register access arbiter: bus status codes,
// access encodings and the transaction state machine encoding.
package rggen_register_access_arbiter_pkg;

    // Response status carried back to the hosts.
    typedef enum logic [1:0] {
        STATUS_OKAY   = 2'b00,
        STATUS_EXOKAY = 2'b01,
        STATUS_SLVERR = 2'b10,
        STATUS_DECERR = 2'b11
    } rggen_status_e;

    // Access type; bit0 set means a write.
    typedef enum logic [1:0] {
        ACCESS_POSTED_WRITE = 2'b01,
        ACCESS_READ         = 2'b10,
        ACCESS_WRITE        = 2'b11
    } rggen_access_e;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_BUSY,
        STATE_RESP
    } arbiter_state_e;

endpackage

// File: rtl/rggen_register_access_arbiter_if.sv
// Bundle between HOSTS requesters, the arbiter and one register block.
// master: arbiter view; slave: hosts + register block (environment) view.
interface rggen_register_access_arbiter_if #(
    parameter int HOSTS         = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);

    logic [HOSTS-1:0]                   host_valid;
    logic [2*HOSTS-1:0]                 host_access;
    logic [ADDRESS_WIDTH*HOSTS-1:0]     host_address;
    logic [BUS_WIDTH*HOSTS-1:0]         host_write_data;
    logic [BUS_WIDTH/8*HOSTS-1:0]       host_strobe;
    logic [HOSTS-1:0]                   host_ready;
    logic [1:0]                         host_status;
    logic [BUS_WIDTH-1:0]               host_read_data;

    logic                               register_valid;
    logic [1:0]                         register_access;
    logic [ADDRESS_WIDTH-1:0]           register_address;
    logic [BUS_WIDTH-1:0]               register_write_data;
    logic [BUS_WIDTH/8-1:0]             register_strobe;
    logic                               register_active;
    logic                               register_ready;
    logic [1:0]                         register_status;
    logic [BUS_WIDTH-1:0]               register_read_data;

    modport master (
        input  host_valid,
        input  host_access,
        input  host_address,
        input  host_write_data,
        input  host_strobe,
        output host_ready,
        output host_status,
        output host_read_data,
        output register_valid,
        output register_access,
        output register_address,
        output register_write_data,
        output register_strobe,
        input  register_active,
        input  register_ready,
        input  register_status,
        input  register_read_data
    );

    modport slave (
        output host_valid,
        output host_access,
        output host_address,
        output host_write_data,
        output host_strobe,
        input  host_ready,
        input  host_status,
        input  host_read_data,
        input  register_valid,
        input  register_access,
        input  register_address,
        input  register_write_data,
        input  register_strobe,
        output register_active,
        output register_ready,
        output register_status,
        output register_read_data
    );

endinterface

// File: rtl/rggen_register_access_arbiter_round_robin.sv
// Combinational round-robin picker: one-hot grant of the first request
// at or after pointer. Ports: request, pointer in; grant (one-hot) out.
module rggen_round_robin_arbiter
    import rggen_register_access_arbiter_pkg::*;
#(
    parameter int HOSTS = 2
)(
    input  logic [HOSTS-1:0]         request,
    input  logic [$clog2(HOSTS)-1:0] pointer,
    output logic [HOSTS-1:0]         grant
);

    localparam int PW = $clog2(HOSTS);

    logic          found;
    logic [PW-1:0] index;

    always_comb begin
        grant = '0;
        found = 1'b0;
        index = '0;
        for (int i = 0; i < HOSTS; i++) begin
            // Scan pointer, pointer+1, ... wrapping HOSTS-1 -> 0.
            index = PW'((int'(pointer) + i) % HOSTS);
            if (!found && request[index]) begin
                grant[index] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rggen_register_access_arbiter.sv
// Shares one register-block port among HOSTS requesters, one transaction
// in flight, with decode-error and timeout responses. Ports: i_clk, i_rst, bus.
module rggen_register_access_arbiter
    import rggen_register_access_arbiter_pkg::*;
#(
    parameter int HOSTS         = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int TIMEOUT       = 0
)(
    input  logic                             i_clk,
    input  logic                             i_rst,
    rggen_register_access_arbiter_if.master  bus
);

    localparam int PW = $clog2(HOSTS);
    localparam int SW = BUS_WIDTH / 8;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arbiter_state_e         state;
    arbiter_state_e         state_next;
    logic [PW-1:0]          grant;
    logic [PW-1:0]          pointer;
    logic [PW-1:0]          rr_index;
    logic [HOSTS-1:0]       rr_grant;
    logic [TW-1:0]          timer;
    logic [1:0]             status_q;
    logic [1:0]             status_next;
    logic [BUS_WIDTH-1:0]   data_q;
    logic [BUS_WIDTH-1:0]   data_next;
    logic                   timeout_hit;
    logic                   busy;
    logic                   resp;
    logic                   start;

    logic [1:0]             sel_access;
    logic [ADDRESS_WIDTH-1:0] sel_address;
    logic [BUS_WIDTH-1:0]   sel_write_data;
    logic [SW-1:0]          sel_strobe;

    rggen_round_robin_arbiter #(
        .HOSTS   (HOSTS)
    ) u_round_robin (
        .request (bus.host_valid),
        .pointer (pointer),
        .grant   (rr_grant)
    );

    always_comb begin
        rr_index = '0;
        for (int i = 0; i < HOSTS; i++) begin
            if (rr_grant[i]) begin
                rr_index = PW'(i);
            end
        end
    end

    assign busy  = (state == STATE_BUSY);
    assign resp  = (state == STATE_RESP);
    assign start = (state == STATE_IDLE) && (|bus.host_valid);

    assign timeout_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        status_next = status_q;
        data_next   = data_q;
        unique case (state)
            STATE_IDLE: begin
                if (|bus.host_valid) begin
                    state_next = STATE_BUSY;
                end
            end
            STATE_BUSY: begin
                // No register matched: decode error, ready is ignored.
                if (!bus.register_active) begin
                    status_next = STATUS_DECERR;
                    data_next   = '0;
                    state_next  = STATE_RESP;
                end else if (bus.register_ready) begin
                    // Ready wins over a timeout expiring in the same cycle.
                    status_next = bus.register_status;
                    data_next   = bus.register_read_data;
                    state_next  = STATE_RESP;
                end else if (timeout_hit) begin
                    status_next = STATUS_SLVERR;
                    data_next   = '0;
                    state_next  = STATE_RESP;
                end
            end
            STATE_RESP: begin
                status_next = '0;
                data_next   = '0;
                state_next  = STATE_IDLE;
            end
            default: begin
                state_next = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant    <= '0;
            pointer  <= '0;
            timer    <= '0;
            status_q <= '0;
            data_q   <= '0;
        end else begin
            status_q <= status_next;
            data_q   <= data_next;
            if (start) begin
                grant <= rr_index;
                timer <= '0;
            end else if (busy) begin
                timer <= timer + TW'(1);
            end
            if (resp) begin
                pointer <= (grant == PW'(HOSTS - 1)) ? '0 : grant + PW'(1);
            end
        end
    end

    // Downstream request follows the registered grant only.
    always_comb begin
        sel_access     = '0;
        sel_address    = '0;
        sel_write_data = '0;
        sel_strobe     = '0;
        for (int i = 0; i < HOSTS; i++) begin
            if (grant == PW'(i)) begin
                sel_access     = bus.host_access[2*i +: 2];
                sel_address    = bus.host_address[ADDRESS_WIDTH*i +: ADDRESS_WIDTH];
                sel_write_data = bus.host_write_data[BUS_WIDTH*i +: BUS_WIDTH];
                sel_strobe     = bus.host_strobe[SW*i +: SW];
            end
        end
    end

    assign bus.register_valid      = busy;
    assign bus.register_access     = busy ? sel_access     : '0;
    assign bus.register_address    = busy ? sel_address    : '0;
    assign bus.register_write_data = busy ? sel_write_data : '0;
    assign bus.register_strobe     = busy ? sel_strobe     : '0;

    assign bus.host_ready     = resp ? (HOSTS'(1) << grant) : '0;
    assign bus.host_status    = resp ? status_q : '0;
    assign bus.host_read_data = resp ? data_q   : '0;

endmodule
